rst_seq: RTL

Parametrised reset sequencer: the successor to the two-flop reset synchroniser. It takes N_SRC asynchronous active-low reset requests plus a software reset pulse and synchronises each request through a SYNC_STAGES-deep chain. It enforces a minimum quiet period, then releases N_OUT active-low domain resets one at a time, STAGGER cycles apart. It sits at the top of the design, between the push-button and watchdog reset sources and every block's rst_n.

---
 rtl/rst_seq_pkg.sv | 19 +
 rtl/sync_chain.sv | 25 ++
 rtl/rst_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// The FSM state encoding and the counter-width rule live here.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT,
        HOLD,
        RELEASE,
        RUN
    } state_t;

    // The counter must reach both MIN_ASSERT-1 and STAGGER-1.
    function automatic int cnt_width(input int min_assert, input int stagger);
        int longest;
        longest = (min_assert > stagger) ? min_assert : stagger;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// One-bit multi-stage synchroniser, falling-edge clocked, clears to 0
// (request asserted) on a synchronous active-high reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: non-blocking so each stage captures its neighbour's pre-edge value.
    always_ff @(negedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: synchronises reset requests, waits out a quiet period,
// then releases the domain resets one by one, STAGGER cycles apart.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int N_SRC       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int N_OUT       = 3,
    parameter int MIN_ASSERT  = 16,
    parameter int STAGGER     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req_n,
    input  logic             sw_req,
    input  logic             cause_clr,
    output logic [N_OUT-1:0] rst_n_out,
    output logic             all_released,
    output logic [N_SRC:0]   cause
);

    localparam int CW = cnt_width(MIN_ASSERT, STAGGER);
    localparam int IW = $clog2(N_OUT) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_OUT - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [N_SRC-1:0] req_sync_n;
    logic [N_OUT-1:0] release_mask;
    logic             active;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        sync_chain #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk(clk),
            .rst(rst),
            .d  (req_n[g]),
            .q  (req_sync_n[g])
        );
    end

    assign active = ~&req_sync_n | sw_req;

    // One-hot selector of the output released next.
    always_comb begin
        release_mask = '0;
        for (int i = 0; i < N_OUT; i++) begin
            release_mask[i] = (IW'(i) == idx);
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state        <= ASSERT;
            cnt          <= '0;
            idx          <= '0;
            rst_n_out    <= '0;
            all_released <= 1'b0;
        end else if (active) begin
            // Any request collapses every output at once, from any state.
            state        <= ASSERT;
            cnt          <= '0;
            idx          <= '0;
            rst_n_out    <= '0;
            all_released <= 1'b0;
        end else begin
            case (state)
                ASSERT: begin
                    rst_n_out    <= '0;
                    all_released <= 1'b0;
                    cnt          <= '0;
                    idx          <= '0;
                    state        <= HOLD;
                end

                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        if (N_OUT == 1) begin
                            state        <= RUN;
                            rst_n_out    <= '1;
                            all_released <= 1'b1;
                        end else begin
                            state     <= RELEASE;
                            rst_n_out <= N_OUT'(1);
                            idx       <= IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                RELEASE: begin
                    if (cnt == STAG_LAST) begin
                        cnt       <= '0;
                        rst_n_out <= rst_n_out | release_mask;
                        idx       <= idx + IW'(1);
                        if (idx == IDX_LAST) begin
                            state        <= RUN;
                            all_released <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                RUN: begin
                    rst_n_out    <= '1;
                    all_released <= 1'b1;
                end

                default: begin
                    state        <= ASSERT;
                    cnt          <= '0;
                    idx          <= '0;
                    rst_n_out    <= '0;
                    all_released <= 1'b0;
                end
            endcase
        end
    end

    // Set beats clear on the same edge, bit by bit.
    always_ff @(negedge clk) begin
        if (rst) begin
            cause <= '0;
        end else begin
            cause <= (cause_clr ? '0 : cause) | {sw_req, ~req_sync_n};
        end
    end

    // Outputs are always a thermometer code and all_released mirrors it.
    a_thermometer : assert property (@(negedge clk) disable iff (rst)
        ((rst_n_out + N_OUT'(1)) & rst_n_out) == '0);
    a_all_released : assert property (@(negedge clk) disable iff (rst)
        all_released == &rst_n_out);

endmodule
